// File: rtl/io_port_controller.sv
// Device end of the processor's IN/OUT/interrupt interface: input FIFO feeding inputPort,
// 2-entry output buffer capturing outputPort, and a holdoff-paced interrupt generator.
module io_port_controller #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned IRQ_GAP = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ext_in_data,
  input  logic        ext_in_valid,
  output logic        ext_in_ready,
  output logic [15:0] inputPort,
  input  logic        in_rd,
  input  logic [15:0] outputPort,
  input  logic        out_wr,
  output logic [15:0] ext_out_data,
  output logic        ext_out_valid,
  input  logic        ext_out_ready,
  input  logic        irq_en,
  output logic        interrupt,
  output logic        in_underflow,
  output logic        out_overflow,
  input  logic        clr_flags
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned GW = (IRQ_GAP > 1) ? $clog2(IRQ_GAP) : 1;

  typedef enum logic [1:0] {StIdle, StPulse, StHold} irq_state_e;

  // Input FIFO
  logic [15:0]   in_mem [DEPTH];
  logic [AW-1:0] in_wptr_q, in_wptr_d, in_rptr_q, in_rptr_d;
  logic [CW-1:0] in_count_q, in_count_d;
  logic          in_empty, in_push, in_pop;

  assign in_empty     = (in_count_q == '0);
  assign ext_in_ready = (in_count_q != CW'(DEPTH));
  assign in_push      = ext_in_valid & ext_in_ready;
  assign in_pop       = in_rd & ~in_empty;
  assign inputPort    = in_empty ? 16'h0000 : in_mem[in_rptr_q];

  always_comb begin
    in_wptr_d  = in_wptr_q;
    in_rptr_d  = in_rptr_q;
    in_count_d = in_count_q + CW'(in_push) - CW'(in_pop);
    if (in_push) in_wptr_d = in_wptr_q + AW'(1);
    if (in_pop)  in_rptr_d = in_rptr_q + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (in_push) in_mem[in_wptr_q] <= ext_in_data;
  end

  // Output buffer: the write slot is head+count mod 2, which is the popped slot when full.
  logic [15:0] out_mem [2];
  logic        out_head_q, out_head_d;
  logic [1:0]  out_count_q, out_count_d;
  logic        out_pop, out_acc, out_wslot;

  assign ext_out_valid = (out_count_q != 2'd0);
  assign ext_out_data  = ext_out_valid ? out_mem[out_head_q] : 16'h0000;
  assign out_pop       = ext_out_valid & ext_out_ready;
  assign out_acc       = out_wr & ((out_count_q != 2'd2) | out_pop);
  assign out_wslot     = out_head_q ^ out_count_q[0];

  always_comb begin
    out_head_d  = out_head_q ^ out_pop;
    out_count_d = out_count_q + 2'(out_acc) - 2'(out_pop);
  end

  always_ff @(posedge clk) begin
    if (out_acc) out_mem[out_wslot] <= outputPort;
  end

  // Sticky flags: a set event beats a simultaneous clear
  logic in_underflow_q, in_underflow_d, out_overflow_q, out_overflow_d;

  always_comb begin
    in_underflow_d = (in_rd & in_empty) | (in_underflow_q & ~clr_flags);
    out_overflow_d = (out_wr & ~out_acc) | (out_overflow_q & ~clr_flags);
  end

  assign in_underflow = in_underflow_q;
  assign out_overflow = out_overflow_q;

  // Interrupt FSM
  irq_state_e    irq_state_q, irq_state_d;
  logic [GW-1:0] gap_q, gap_d;

  always_comb begin
    irq_state_d = irq_state_q;
    gap_d       = gap_q;
    unique case (irq_state_q)
      StIdle: begin
        if (irq_en && !in_empty) irq_state_d = StPulse;
      end
      StPulse: begin
        gap_d       = GW'(IRQ_GAP - 1);
        irq_state_d = StHold;
      end
      StHold: begin
        if (gap_q == '0) irq_state_d = StIdle;
        else             gap_d       = gap_q - GW'(1);
      end
      default: irq_state_d = StIdle;
    endcase
  end

  always_comb begin
    interrupt = (irq_state_q == StPulse);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_wptr_q      <= '0;
      in_rptr_q      <= '0;
      in_count_q     <= '0;
      out_head_q     <= 1'b0;
      out_count_q    <= 2'd0;
      in_underflow_q <= 1'b0;
      out_overflow_q <= 1'b0;
      irq_state_q    <= StIdle;
      gap_q          <= '0;
    end else begin
      in_wptr_q      <= in_wptr_d;
      in_rptr_q      <= in_rptr_d;
      in_count_q     <= in_count_d;
      out_head_q     <= out_head_d;
      out_count_q    <= out_count_d;
      in_underflow_q <= in_underflow_d;
      out_overflow_q <= out_overflow_d;
      irq_state_q    <= irq_state_d;
      gap_q          <= gap_d;
    end
  end

endmodule
